ram_sp_sr_be: RTL and testbench
===============================

# ram_sp_sr_be

Parametrised single-port synchronous RAM with per-byte write enables and a configurable registered read latency. It has a selectable read-during-write mode and a built-in post-reset clear sequencer. This is the next generation of the team's asynchronous single-port RAM models: separate read/write data buses replace the tristate inout. It is the standard scratch/buffer memory behind bus slaves and DMA-style blocks, where deterministic post-reset contents are required.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8, address bits
- RAM_DEPTH, 1 << ADDR_WIDTH, number of words; must be ≤ 2^ADDR_WIDTH
- READ_LATENCY, 1, cycles from accepted request to rvalid; legal range 1..4
- RDW_MODE, 0, data returned on a write access: 0 = old contents (read-first), 1 = merged new contents (write-first)
- CLEAR_VALUE, 0, word written to every location by the clear sequence

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- cs  input  1  access request
- we  input  1  1 = write, 0 = read; qualified by cs
- be  input  DATA_WIDTH/8  byte-lane write enables; be[i] covers wdata[8i+7:8i]
- address  input  ADDR_WIDTH  word address
- wdata  input  DATA_WIDTH  write data
- ready  output  1  RAM accepts requests
- rdata  output  DATA_WIDTH  returned word
- rvalid  output  1  rdata/rerr valid (one-cycle pulse per access)
- rerr  output  1  access address was ≥ RAM_DEPTH

## Operation
- States: CLEAR, RUN.
- Reset: rst = 1 forces state CLEAR, clear counter 0, ready 0, rvalid 0, rerr 0, rdata 0, and flushes the read pipeline. Memory contents are not touched while rst is high.
- CLEAR:
  - On each edge with rst = 0, write CLEAR_VALUE to mem[counter] and increment the counter.
  - After writing RAM_DEPTH−1, go to RUN and set ready = 1.
  - cs is ignored: no write, no rvalid.
- RUN:
  - An access is accepted on an edge where cs = 1 and ready = 1.
  - Every accepted access, read or write, produces exactly one rvalid pulse.
  - Read: returns mem[address].
  - Write: for each i with be[i] = 1, update byte lane i; other lanes are unchanged. be = 0 makes the write a no-op that still returns data.
  - Write return data: RDW_MODE 0 returns the pre-write word; RDW_MODE 1 returns the post-merge word.
  - Out of range (address ≥ RAM_DEPTH): the write is dropped, rdata = 0, rerr = 1 with rvalid.
- rst asserted mid-operation (during CLEAR or RUN, with reads in flight) discards all in-flight responses; no rvalid appears after the reset edge. The clear sequence restarts from address 0.

## Timing
- Request sampled at edge T → rvalid = 1 and rdata/rerr valid after edge T+READ_LATENCY, for exactly one cycle.
- When rvalid = 0, rdata holds its last value and rerr = 0.
- Throughput: one access per cycle. Back-to-back accesses give back-to-back rvalid in request order.
- Read after write to the same address on consecutive edges returns the written data; no hazard window at any latency.
- Clear: with E0 as the first edge where rst = 0, clear writes occur at E0..E0+RAM_DEPTH−1. ready = 1 after edge E0+RAM_DEPTH−1, and the first accepted access is at E0+RAM_DEPTH.
- ready never drops in RUN. Only rst deasserts it.

## Structure
- Shared package ram_pkg:
  - constants RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1
  - state encoding ST_CLEAR, ST_RUN
  - function for byte-lane count, DATA_WIDTH/8
  - parameter legality checks: DATA_WIDTH % 8, READ_LATENCY range, RAM_DEPTH bound
- Sub-module ram_rd_pipe: delay line carrying {valid, err, data} through READ_LATENCY−1 stages after the memory output register, with synchronous flush on rst.
- Top level holds the memory array, the byte-lane merge, the RDW mux, the clear counter and the FSM.

## Test plan
- Reset/clear:
  - Stimulus: RAM_DEPTH = 16, CLEAR_VALUE = 32'hDEADBEEF; pre-fill random data, pulse rst for 3 cycles.
  - Required: ready rises exactly 16 cycles after rst falls; reads of addresses 0..15 all return 32'hDEADBEEF.
- Byte enables:
  - Stimulus: write 32'h11223344 to address 5 with be = 4'hF, then 32'hAABBCCDD with be = 4'b0101; read address 5.
  - Required: the read returns 32'h11BB33DD.
- RDW mode:
  - Stimulus: address 7 holds 32'h0; write 32'h12345678, be = 4'hF.
  - Required: rdata = 0 with RDW_MODE 0, 32'h12345678 with RDW_MODE 1.
- Latency/throughput, READ_LATENCY = 3:
  - Stimulus: issue reads at edges T, T+1, T+2.
  - Required: rvalid at T+3, T+4, T+5 with data in request order. A write at T followed by a read of the same address at T+1 returns the new data.
- Out of range:
  - Stimulus: ADDR_WIDTH = 4, RAM_DEPTH = 12; write to address 13, then read address 13.
  - Required: both accesses return rvalid with rerr = 1 and rdata = 0; addresses 0..11 are unchanged.
- Reset mid-flight:
  - Stimulus: READ_LATENCY = 2; issue a read, then assert rst one cycle later.
  - Required: no rvalid after the reset edge; ready = 0; the clear sequence restarts from address 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the single-port synchronous RAM family: read-during-write
// modes, controller state encoding and parameter legality rules.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic bit params_legal(input int data_width,
                                      input int addr_width,
                                      input int ram_depth,
                                      input int read_latency,
                                      input int rdw_mode);
    longint max_depth;
    max_depth = longint'(1) << addr_width;
    return (data_width > 0) && (data_width % 8 == 0) &&
           (addr_width > 0) && (addr_width < 63) &&
           (ram_depth >= 1) && (longint'(ram_depth) <= max_depth) &&
           (read_latency >= 1) && (read_latency <= 4) &&
           ((rdw_mode == RDW_READ_FIRST) || (rdw_mode == RDW_WRITE_FIRST));
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Response delay line: carries {valid, err, data} through STAGES extra registers.
// Data only advances with valid, so the last stage holds the most recent response.
module ram_rd_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    // Clock and reset have no load when there are no extra stages.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst};

    assign out_valid = in_valid;
    assign out_err   = in_err;
    assign out_data  = in_data;
  end else begin : g_delay
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] err_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        err_q   <= '0;
        for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= in_valid;
        err_q[0]   <= in_valid & in_err;
        if (in_valid) data_q[0] <= in_data;
        for (int i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          err_q[i]   <= valid_q[i-1] & err_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/ram_sp_sr_be.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write
// behaviour, READ_LATENCY-cycle responses and a post-reset clear sequencer.
module ram_sp_sr_be
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RDW_MODE     = RDW_READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    rerr
);

  localparam int NUM_LANES = byte_lanes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  if (!params_legal(DATA_WIDTH, ADDR_WIDTH, RAM_DEPTH, READ_LATENCY, RDW_MODE)) begin : g_bad_params
    $error("ram_sp_sr_be: illegal parameter combination");
  end

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  clr_we;
  logic                  clr_last;

  assign clr_last = (clr_cnt_q == LAST_ADDR);
  assign ready    = (state_q == ST_RUN);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_last) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Request stage: the access is captured here and performed on the next edge.
  logic                  accept;
  logic                  req_valid_q;
  logic                  req_we_q;
  logic [NUM_LANES-1:0]  req_be_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;

  assign accept = cs & ready;

  always_ff @(posedge clk) begin
    if (rst) req_valid_q <= 1'b0;
    else     req_valid_q <= accept;
  end

  // NOTE: payload registers carry no reset; they are only looked at when req_valid_q is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we_q    <= we;
      req_be_q    <= be;
      req_addr_q  <= address;
      req_wdata_q <= wdata;
    end
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  in_range;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign in_range = ({1'b0, req_addr_q} < DEPTH_LIMIT);
  assign old_word = in_range ? mem[req_addr_q] : '0;

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (req_be_q[i]) merged_word[8*i +: 8] = req_wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    rd_word = old_word;
    if (!in_range)                                       rd_word = '0;
    else if (req_we_q && (RDW_MODE == RDW_WRITE_FIRST))  rd_word = merged_word;
  end

  // NOTE: the array has no reset; the clear sequencer gives it defined contents instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_cnt_q] <= CLEAR_VALUE;
      end else if (req_valid_q && req_we_q && in_range) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (req_be_q[i]) mem[req_addr_q][8*i +: 8] <= req_wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Memory output register; rdata holds its last value between responses.
  logic                  s1_valid_q;
  logic                  s1_err_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= req_valid_q;
      s1_err_q   <= req_valid_q & ~in_range;
      if (req_valid_q) s1_data_q <= rd_word;
    end
  end

  ram_rd_pipe #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (READ_LATENCY - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_q),
    .in_err    (s1_err_q),
    .in_data   (s1_data_q),
    .out_valid (rvalid),
    .out_err   (rerr),
    .out_data  (rdata)
  );

endmodule

// File: tb/tb_ram_sp_sr_be.sv
// Directed bench for ram_sp_sr_be: three instances share one request bus and
// differ in depth, latency, read-during-write mode and clear value.
module tb_ram_sp_sr_be;

  logic        clk = 1'b0;
  logic        rst, cs, we;
  logic [3:0]  be, address;
  logic [31:0] wdata;

  logic        ready_a, rvalid_a, rerr_a;
  logic [31:0] rdata_a;
  logic        ready_b, rvalid_b, rerr_b;
  logic [31:0] rdata_b;
  logic        ready_c, rvalid_c, rerr_c;
  logic [31:0] rdata_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: depth 16, latency 1, read-first, clears to DEADBEEF
  ram_sp_sr_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16), .READ_LATENCY(1),
                 .RDW_MODE(0), .CLEAR_VALUE(32'hDEADBEEF)) dut_a (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .address(address), .wdata(wdata),
    .ready(ready_a), .rdata(rdata_a), .rvalid(rvalid_a), .rerr(rerr_a));

  // b: depth 12, latency 3, write-first, clears to 0
  ram_sp_sr_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(12), .READ_LATENCY(3),
                 .RDW_MODE(1), .CLEAR_VALUE(32'h0)) dut_b (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .address(address), .wdata(wdata),
    .ready(ready_b), .rdata(rdata_b), .rvalid(rvalid_b), .rerr(rerr_b));

  // c: depth 16, latency 2, read-first, clears to 0
  ram_sp_sr_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16), .READ_LATENCY(2),
                 .RDW_MODE(0), .CLEAR_VALUE(32'h0)) dut_c (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .address(address), .wdata(wdata),
    .ready(ready_c), .rdata(rdata_c), .rvalid(rvalid_c), .rerr(rerr_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c_in, input logic w_in, input logic [3:0] be_in,
                       input logic [3:0] a_in, input logic [31:0] d_in);
    cs = c_in; we = w_in; be = be_in; address = a_in; wdata = d_in;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({ready_a, rvalid_a, rerr_a, rdata_a} !== 35'h0) begin
      n_fail++; $display("FAIL reset_a: {ready,rvalid,rerr,rdata}=%h, required 0", {ready_a, rvalid_a, rerr_a, rdata_a});
    end
    n_checks++;
    if ({ready_b, rvalid_b, rerr_b, rdata_b} !== 35'h0) begin
      n_fail++; $display("FAIL reset_b: {ready,rvalid,rerr,rdata}=%h, required 0", {ready_b, rvalid_b, rerr_b, rdata_b});
    end
    n_checks++;
    if ({ready_c, rvalid_c, rerr_c, rdata_c} !== 35'h0) begin
      n_fail++; $display("FAIL reset_c: {ready,rvalid,rerr,rdata}=%h, required 0", {ready_c, rvalid_c, rerr_c, rdata_c});
    end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 11 || k == 12) begin
        n_checks++;
        if (ready_b !== (k == 12)) begin
          n_fail++; $display("FAIL ready_b_edge%0d: ready=%b, required %b", k, ready_b, (k == 12));
        end
      end
      if (k == 15 || k == 16) begin
        n_checks++;
        if (ready_a !== (k == 16)) begin
          n_fail++; $display("FAIL ready_a_edge%0d: ready=%b, required %b", k, ready_a, (k == 16));
        end
      end
    end
  endtask

  task automatic test_clear();
    int seen_a;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'hF, 4'(i), $urandom());
      tick();
    end
    idle();
    repeat (5) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    // Requests held during the clear sequence must be ignored by a.
    drive(1'b1, 1'b1, 4'hF, 4'd3, 32'h0);
    seen_a = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (rvalid_a) seen_a++;
      if (k == 15 || k == 16) begin
        n_checks++;
        if (ready_a !== (k == 16)) begin
          n_fail++; $display("FAIL clear_ready_edge%0d: ready=%b, required %b", k, ready_a, (k == 16));
        end
      end
    end
    idle();
    n_checks++;
    if (seen_a !== 0) begin
      n_fail++; $display("FAIL clear_cs_ignored: rvalid pulses=%0d, required 0", seen_a);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
      tick();
      idle();
      tick();
      n_checks++;
      if ({rvalid_a, rerr_a, rdata_a} !== {2'b10, 32'hDEADBEEF}) begin
        n_fail++; $display("FAIL clear_read_%0d: {rvalid,rerr,rdata}=%h, required %h", i, {rvalid_a, rerr_a, rdata_a}, {2'b10, 32'hDEADBEEF});
      end
    end
  endtask

  task automatic test_byte_enables();
    drive(1'b1, 1'b1, 4'hF, 4'd5, 32'h11223344);
    tick();
    drive(1'b1, 1'b1, 4'b0101, 4'd5, 32'hAABBCCDD);
    tick();
    n_checks++;
    if ({rvalid_a, rerr_a, rdata_a} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL be_write1_old: {rvalid,rerr,rdata}=%h, required %h", {rvalid_a, rerr_a, rdata_a}, {2'b10, 32'hDEADBEEF});
    end
    drive(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    tick();
    n_checks++;
    if ({rvalid_a, rerr_a, rdata_a} !== {2'b10, 32'h11223344}) begin
      n_fail++; $display("FAIL be_write2_old: {rvalid,rerr,rdata}=%h, required %h", {rvalid_a, rerr_a, rdata_a}, {2'b10, 32'h11223344});
    end
    idle();
    tick();
    n_checks++;
    if ({rvalid_a, rerr_a, rdata_a} !== {2'b10, 32'h11BB33DD}) begin
      n_fail++; $display("FAIL be_read: {rvalid,rerr,rdata}=%h, required %h", {rvalid_a, rerr_a, rdata_a}, {2'b10, 32'h11BB33DD});
    end
    repeat (3) tick();
  endtask

  task automatic test_rdw();
    drive(1'b1, 1'b1, 4'hF, 4'd7, 32'h0);
    tick();
    drive(1'b1, 1'b1, 4'hF, 4'd7, 32'h12345678);
    tick();
    idle();
    tick();
    n_checks++;
    if ({rvalid_a, rdata_a} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL rdw_read_first: {rvalid,rdata}=%h, required %h", {rvalid_a, rdata_a}, {1'b1, 32'h0});
    end
    tick();
    n_checks++;
    if ({rvalid_b, rdata_b} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL rdw_write_first_zero: {rvalid,rdata}=%h, required %h", {rvalid_b, rdata_b}, {1'b1, 32'h0});
    end
    tick();
    n_checks++;
    if ({rvalid_b, rdata_b} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL rdw_write_first: {rvalid,rdata}=%h, required %h", {rvalid_b, rdata_b}, {1'b1, 32'h12345678});
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'hA0A0A0A0; exp_q[1] = 32'hA0A0A0A0;
    exp_q[2] = 32'h11BB33DD; exp_q[3] = 32'h12345678;
    drive(1'b1, 1'b1, 4'hF, 4'd2, 32'hA0A0A0A0);
    tick();
    drive(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
    tick();
    drive(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    tick();
    n_checks++;
    if (rvalid_b !== 1'b0) begin
      n_fail++; $display("FAIL lat3_early: rvalid=%b two edges after request, required 0", rvalid_b);
    end
    drive(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      n_checks++;
      if ({rvalid_b, rerr_b, rdata_b} !== {2'b10, exp_q[i]}) begin
        n_fail++; $display("FAIL lat3_resp%0d: {rvalid,rerr,rdata}=%h, required %h", i, {rvalid_b, rerr_b, rdata_b}, {2'b10, exp_q[i]});
      end
    end
    tick();
    n_checks++;
    if ({rvalid_b, rerr_b, rdata_b} !== {2'b00, 32'h12345678}) begin
      n_fail++; $display("FAIL lat3_hold: {rvalid,rerr,rdata}=%h, required %h", {rvalid_b, rerr_b, rdata_b}, {2'b00, 32'h12345678});
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp_b [12];
    for (int i = 0; i < 12; i++) exp_b[i] = 32'h0;
    exp_b[2] = 32'hA0A0A0A0;
    exp_b[5] = 32'h11BB33DD;
    exp_b[7] = 32'h12345678;
    drive(1'b1, 1'b1, 4'hF, 4'd13, 32'hFFFFFFFF);
    tick();
    drive(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
    tick();
    idle();
    tick();
    tick();
    n_checks++;
    if ({rvalid_b, rerr_b, rdata_b} !== {2'b11, 32'h0}) begin
      n_fail++; $display("FAIL oor_write: {rvalid,rerr,rdata}=%h, required %h", {rvalid_b, rerr_b, rdata_b}, {2'b11, 32'h0});
    end
    tick();
    n_checks++;
    if ({rvalid_b, rerr_b, rdata_b} !== {2'b11, 32'h0}) begin
      n_fail++; $display("FAIL oor_read: {rvalid,rerr,rdata}=%h, required %h", {rvalid_b, rerr_b, rdata_b}, {2'b11, 32'h0});
    end
    tick();
    n_checks++;
    if ({rvalid_b, rerr_b} !== 2'b00) begin
      n_fail++; $display("FAIL oor_rerr_idle: {rvalid,rerr}=%b, required 00", {rvalid_b, rerr_b});
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
      tick();
      idle();
      repeat (3) tick();
      n_checks++;
      if ({rvalid_b, rerr_b, rdata_b} !== {2'b10, exp_b[i]}) begin
        n_fail++; $display("FAIL oor_unchanged_%0d: {rvalid,rerr,rdata}=%h, required %h", i, {rvalid_b, rerr_b, rdata_b}, {2'b10, exp_b[i]});
      end
    end
  endtask

  task automatic test_reset_midflight();
    int seen_c;
    drive(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({rvalid_c, ready_c} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_edge: {rvalid,ready}=%b, required 00", {rvalid_c, ready_c});
    end
    tick();
    n_checks++;
    if (rvalid_c !== 1'b0) begin
      n_fail++; $display("FAIL mid_flushed: rvalid=%b at original response edge, required 0", rvalid_c);
    end
    tick();
    rst = 1'b0;
    seen_c = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (rvalid_c) seen_c++;
      if (k == 15 || k == 16) begin
        n_checks++;
        if (ready_c !== (k == 16)) begin
          n_fail++; $display("FAIL mid_ready_edge%0d: ready=%b, required %b", k, ready_c, (k == 16));
        end
      end
    end
    n_checks++;
    if (seen_c !== 0) begin
      n_fail++; $display("FAIL mid_no_rvalid: rvalid pulses=%0d, required 0", seen_c);
    end
    drive(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    tick();
    idle();
    repeat (2) tick();
    n_checks++;
    if ({rvalid_c, rerr_c, rdata_c} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL mid_recleared: {rvalid,rerr,rdata}=%h, required %h", {rvalid_c, rerr_c, rdata_c}, {2'b10, 32'h0});
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_enables();
    test_rdw();
    test_back_to_back();
    test_out_of_range();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
